// File: rtl/arc4_pkg.sv
// Shared types and sizes for the ARC4 S-memory datapath.
// The S memory is a 256-entry byte array. Its address width is derived
// from the depth so that the two values always agree.
package arc4_pkg;

    localparam int S_DEPTH  = 256;
    localparam int S_ADDR_W = $clog2(S_DEPTH);
    localparam int S_DATA_W = 8;

    // Reader phases: waiting for a request, issuing reads, and waiting
    // for the last buffered byte to leave.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Small circular FIFO that sits between the S-memory read port and the
// output stream. It absorbs the read latency when the consumer stalls.
// A push and a pop may happen in the same cycle, including when the FIFO
// is full, because the pop frees the slot that the push takes.
module rd_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly, so DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy. Storage is cleared as well, so the
    // head reads as zero straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/s_mem_reader.sv
// Streams a run of bytes out of the S memory. A request (start address and
// byte count) is taken on the en/rdy handshake. The bytes are then
// delivered on a valid/ready stream, and out_last marks the final byte.
// Reads are only issued while a buffer slot is guaranteed for the result.
// Because of this, a stalled consumer never causes a byte to be lost or
// repeated.
module s_mem_reader
    import arc4_pkg::*;
#(
    parameter int ADDR_W   = S_ADDR_W,
    parameter int DATA_W   = S_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rddata,
    output logic              wren,
    output logic [DATA_W-1:0] wrdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int BUF_D = READ_LAT + 1;
    localparam int CNT_W = $clog2(BUF_D + 1);

    rd_state_t             state;
    logic [ADDR_W:0]       remaining;
    logic [READ_LAT-1:0]   infl_valid;
    logic [READ_LAT-1:0]   infl_last;
    logic                  issue;
    int                    infl_cnt;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_W:0]       fifo_head;
    logic [CNT_W-1:0]      fifo_count;

    // This block never writes the S memory.
    assign wren   = 1'b0;
    assign wrdata = '0;

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[DATA_W-1:0];
    assign out_last  = fifo_head[DATA_W];
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = infl_valid[READ_LAT-1];

    // Issue a read only when every outstanding read still has a buffer slot.
    // A byte that leaves on this edge frees its slot immediately, which
    // keeps the stream at one byte per cycle.
    always_comb begin
        infl_cnt = 0;
        for (int i = 0; i < READ_LAT; i++) begin
            infl_cnt = infl_cnt + int'(infl_valid[i]);
        end
        issue = (state == ISSUE) &&
                ((infl_cnt + int'(fifo_count) - int'(fifo_pop)) < BUF_D);
    end

    // Request FSM. It owns the address counter and the count of reads
    // still to issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            addr      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        addr      <= start_addr;
                        remaining <= (count == '0) ? {1'b1, {ADDR_W{1'b0}}} : count;
                        rdy       <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - (ADDR_W+1)'(1);
                        if (remaining == (ADDR_W+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_pop && out_last) begin
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Track each issued read through the memory latency, together with
    // its last tag, so that rddata is captured on the correct cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_valid <= '0;
            infl_last  <= '0;
        end else begin
            infl_valid[0] <= issue;
            infl_last[0]  <= issue && (remaining == (ADDR_W+1)'(1));
            for (int i = 1; i < READ_LAT; i++) begin
                infl_valid[i] <= infl_valid[i-1];
                infl_last[i]  <= infl_last[i-1];
            end
        end
    end

    // If the credit accounting ever broke, a push would reach a full FIFO
    // with nothing leaving. This assertion flags that case.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_push && fifo_full && !fifo_pop));
        end
    end

    rd_skid_fifo #(
        .DEPTH (BUF_D),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({infl_last[READ_LAT-1], rddata}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_s_mem_reader.sv
// Bench for s_mem_reader. A behavioural S memory with a registered
// address feeds the DUT. Every accepted request expands into the byte run
// it must produce, modulo-256 addressing included, and that run is queued
// as the expected stream. Each handshake pops one expected byte and
// compares it. The bench also watches stalled bytes for stability.
module tb_s_mem_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] start_addr;
    logic [8:0] count;
    logic [7:0] addr;
    logic [7:0] rddata;
    logic       wren;
    logic [7:0] wrdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] smem [256];
    logic [7:0] ram_addr_q;

    int n_compared;
    int n_mismatched;
    int cyc;
    int accept_cyc;
    int first_valid_cyc;
    int ready_mode;
    int rel;
    int first_accept;
    int st;
    logic       hold_pending;
    logic [7:0] hold_data;
    logic       hold_last;

    always #5 clk = ~clk;

    // The S memory registers its address on each edge and shows the data
    // on the following cycle.
    always @(posedge clk) ram_addr_q <= addr;
    assign rddata = smem[ram_addr_q];

    s_mem_reader dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rdy        (rdy),
        .start_addr (start_addr),
        .count      (count),
        .addr       (addr),
        .rddata     (rddata),
        .wren       (wren),
        .wrdata     (wrdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    // Counts one comparison and reports it if it fails.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Advances one clock. It drives out_ready for the coming cycle, then
    // checks the stream at the falling edge.
    task automatic stepCycle();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = ~out_ready;
            3:       out_ready = !(((cyc - accept_cyc) >= 3) && ((cyc - accept_cyc) <= 22));
            default: out_ready = 1'b0;
        endcase
        @(negedge clk);
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, hold_data);
                checkOutput("hold_last", out_last, hold_last);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_byte", out_valid, 0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("data", out_data, e.data);
                    checkOutput("last", out_last, e.last);
                end
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
            hold_last    = out_last;
        end
    endtask

    // Steps until rdy is high, up to a cycle budget.
    task automatic waitRdy(input int budget);
        int k;
        k = 0;
        while (!rdy && k < budget) begin
            stepCycle();
            k++;
        end
        if (!rdy) checkOutput("rdy_timeout", rdy, 1);
    endtask

    // Steps until the request finishes (rdy high, nothing left to
    // receive), then returns the cycle count from the accept edge.
    task automatic waitDone(input int budget, output int rel_cyc);
        int k;
        k = 0;
        while (!(rdy && expq.size() == 0) && k < budget) begin
            stepCycle();
            k++;
        end
        if (!(rdy && expq.size() == 0)) begin
            checkOutput("done_missing_bytes", expq.size(), 0);
            checkOutput("done_rdy", rdy, 1);
            expq.delete();
        end
        rel_cyc = cyc - accept_cyc;
    endtask

    // Issues one request and queues the byte run it should produce.
    task automatic applyStimulus(input int s, input int cn, input int mode, input bit keep_en);
        int n;
        waitRdy(600);
        n = (cn == 0) ? 256 : cn;
        ready_mode = mode;
        start_addr = 8'(s);
        count      = 9'(cn);
        en         = 1'b1;
        accept_cyc = cyc + 1;
        for (int i = 0; i < n; i++) begin
            expq.push_back('{data: smem[8'((s + i) % 256)], last: (i == n - 1)});
        end
        first_valid_cyc = -1;
        stepCycle();
        if (!keep_en) en = 1'b0;
        checkOutput("accept_rdy", rdy, 0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        accept_cyc   = 0;
        first_valid_cyc = -1;
        ready_mode   = 0;
        hold_pending = 1'b0;
        hold_data    = '0;
        hold_last    = 1'b0;
        rst          = 1'b1;
        en           = 1'b0;
        start_addr   = '0;
        count        = '0;
        out_ready    = 1'b1;
        for (int i = 0; i < 256; i++) smem[i] = 8'(i);

        // Reset state.
        stepCycle();
        stepCycle();
        checkOutput("rst_rdy", rdy, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_wren", wren, 0);
        checkOutput("rst_wrdata", wrdata, 0);
        checkOutput("rst_addr", addr, 0);
        rst = 1'b0;
        stepCycle();

        // Full 256-byte dump with identity contents.
        applyStimulus(0, 0, 0, 1'b0);
        waitDone(400, rel);
        checkOutput("dump_first_valid", first_valid_cyc - accept_cyc, 2);
        checkOutput("dump_rdy_latency", rel, 258);

        for (int i = 0; i < 256; i++) smem[i] = 8'($urandom_range(0, 255));

        // Wrap past address 255.
        applyStimulus(250, 10, 0, 1'b0);
        waitDone(100, rel);
        checkOutput("wrap_rdy_latency", rel, 12);
        repeat (5) stepCycle();
        checkOutput("wrap_quiet", out_valid, 0);

        // Long stall. The consumer stops after one byte, so issue halts
        // after three reads: one consumed plus two buffer credits.
        st = $urandom_range(0, 255);
        applyStimulus(st, 30, 3, 1'b0);
        while (cyc - accept_cyc < 5) stepCycle();
        checkOutput("stall_addr_early", addr, (st + 3) % 256);
        while (cyc - accept_cyc < 20) stepCycle();
        checkOutput("stall_addr_late", addr, (st + 3) % 256);
        waitDone(200, rel);

        // Alternating ready.
        applyStimulus($urandom_range(0, 255), 17, 2, 1'b0);
        waitDone(200, rel);

        // Random ready with random requests.
        for (int r = 0; r < 6; r++) begin
            applyStimulus($urandom_range(0, 255), $urandom_range(0, 40), 1, 1'b0);
            waitDone(1200, rel);
        end

        // A request pulsed while busy must be ignored.
        applyStimulus(20, 6, 0, 1'b0);
        stepCycle();
        stepCycle();
        start_addr = 8'd7;
        count      = 9'd4;
        en         = 1'b1;
        stepCycle();
        en = 1'b0;
        checkOutput("busy_rdy", rdy, 0);
        waitDone(100, rel);
        checkOutput("busy_latency", rel, 8);
        repeat (8) stepCycle();
        checkOutput("busy_quiet", out_valid, 0);

        // Reset in the middle of a 20-byte read, after five bytes.
        applyStimulus($urandom_range(0, 255), 20, 0, 1'b0);
        while (expq.size() > 15 && (cyc - accept_cyc) < 100) stepCycle();
        checkOutput("abort_bytes_seen", expq.size(), 15);
        ready_mode = 4;
        stepCycle();
        rst = 1'b1;
        expq.delete();
        stepCycle();
        checkOutput("abort_valid", out_valid, 0);
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("abort_rdy", rdy, 1);
        ready_mode = 0;
        repeat (20) stepCycle();
        checkOutput("abort_quiet", out_valid, 0);

        // Back-to-back requests with en held high.
        applyStimulus(0, 3, 0, 1'b1);
        first_accept = accept_cyc;
        start_addr = 8'd100;
        count      = 9'd2;
        expq.push_back('{data: smem[100], last: 1'b0});
        expq.push_back('{data: smem[101], last: 1'b1});
        waitRdy(50);
        accept_cyc = cyc + 1;
        stepCycle();
        en = 1'b0;
        checkOutput("b2b_accept_rdy", rdy, 0);
        checkOutput("b2b_gap", accept_cyc - first_accept, 6);
        waitDone(50, rel);
        checkOutput("b2b_latency", rel, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
